// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - two-register ALU execute wrapper with accumulator forwarding
module alu_issue_stage #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_set,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_sticky,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic             s1_valid;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [2:0]       s1_op;
    logic             s1_acc;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [31:0]      acc_reg;

    logic s2_free;
    logic s1_adv;
    logic accept;
    logic retire;
    logic s1_legal;
    logic ovf_q;
    logic unused_set;

    assign unused_set = alu_set;

    assign s1_legal = (s1_op == OP_AND) || (s1_op == OP_OR) || (s1_op == OP_ADD) ||
                      (s1_op == OP_SUB) || (s1_op == OP_SLT);

    assign s2_free  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = reset_n && (!s1_valid || s1_adv);
    assign accept   = in_valid && in_ready;
    assign retire   = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // Illegal codes still present a defined op to the ALU; their result is discarded.
    assign alu_a  = s1_acc ? acc_reg : s1_a;
    assign alu_b  = s1_b;
    assign alu_op = s1_legal ? s1_op : OP_ADD;

    assign ovf_q = s1_legal && alu_overflow && ((s1_op == OP_ADD) || (s1_op == OP_SUB));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_acc   <= 1'b0;
            s1_tag   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
            s1_acc   <= in_acc;
            s1_tag   <= in_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid     <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
        end else if (s1_adv) begin
            s2_valid     <= 1'b1;
            out_result   <= s1_legal ? alu_result : 32'd0;
            out_zero     <= s1_legal && alu_zero;
            out_overflow <= ovf_q;
            out_illegal  <= !s1_legal;
            out_tag      <= s1_tag;
        end else if (retire) begin
            s2_valid <= 1'b0;
        end
    end

    // Updating on advance keeps the forwarded value correct for back-to-back acc ops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg <= '0;
        end else if (s1_adv && s1_legal) begin
            acc_reg <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
        end else if (s1_adv && ovf_q) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with ALU model and scoreboard
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_acc = 1'b0;
    logic [3:0]  in_tag = '0;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_set, alu_zero, alu_overflow;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_zero, out_overflow, out_illegal;
    logic [3:0]  out_tag;
    logic        clr_sticky = 1'b0;
    logic        ovf_sticky;
    logic [15:0] retire_count;

    alu_issue_stage #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_set(alu_set), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow),
        .out_illegal(out_illegal), .out_tag(out_tag),
        .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Combinational ALU; SLT raises the subtract overflow like many real ALUs do.
    logic [31:0] alu_diff;
    logic        sub_ovf;
    always_comb begin
        alu_diff     = alu_a - alu_b;
        sub_ovf      = (alu_a[31] != alu_b[31]) && (alu_diff[31] != alu_a[31]);
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b110: begin
                alu_result   = alu_diff;
                alu_overflow = sub_ovf;
            end
            3'b111: begin
                alu_result   = {31'd0, alu_diff[31] ^ sub_ovf};
                alu_overflow = sub_ovf;
            end
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_set  = alu_result[0];
    end

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    logic [31:0] m_acc = '0;
    int   ret_total = 0;
    logic last_acc = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic rec_t ref_exec(input logic [2:0] op, input logic [31:0] a0,
                                      input logic [31:0] b, input logic acc,
                                      input logic [3:0] tag);
        rec_t r;
        logic [31:0] a;
        longint s;
        a = acc ? m_acc : a0;
        r = '0;
        r.tag = tag;
        s = 0;
        case (op)
            3'b000: r.res = a & b;
            3'b001: r.res = a | b;
            3'b010: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r.res = s[31:0];
                r.ovf = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
            end
            3'b110: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r.res = s[31:0];
                r.ovf = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
            end
            3'b111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r.ill = 1'b1;
        endcase
        if (!r.ill) begin
            r.zero = (r.res == 32'd0);
            m_acc  = r.res;
        end
        return r;
    endfunction

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cyc();
        logic af, rf;
        rec_t r;
        @(negedge clk);
        af = in_valid && in_ready;
        rf = out_valid && out_ready;
        if (rf) begin
            r.tag = out_tag; r.res = out_result; r.zero = out_zero;
            r.ovf = out_overflow; r.ill = out_illegal;
            obs_q.push_back(r);
            ret_total++;
        end
        if (af) exp_q.push_back(ref_exec(in_op, in_a, in_b, in_acc, in_tag));
        last_acc = af;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic acc, input logic [3:0] tag);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_acc = acc; in_tag = tag;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (last_acc) return;
        end
        n_tests++; n_fail++;
        $display("FAIL issue_timeout tag=%0d never accepted within 50 cycles", tag);
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold in_ready=%b out_valid=%b exp 0 0", in_ready, out_valid);
        end
        reset_n = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, out_result, out_tag, out_illegal, ovf_sticky, retire_count} !== {1'b1, 32'd0, 4'd0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state in_ready=%b res=%h tag=%h ill=%b sticky=%b cnt=%0d exp 1 0 0 0 0 0",
                     in_ready, out_result, out_tag, out_illegal, ovf_sticky, retire_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        issue(3'b010, 32'd5, 32'd7, 1'b0, 4'd1);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early out_valid=%b exp 0", out_valid); end
        cyc();
        n_tests++;
        if ({out_valid, out_result, out_zero, out_overflow} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_result valid=%b res=%0d zero=%b ovf=%b exp 1 12 0 0", out_valid, out_result, out_zero, out_overflow);
        end
        cyc();
        n_tests++;
        if (retire_count !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_retire cnt=%0d valid=%b exp 1 0", retire_count, out_valid);
        end
    endtask

    task automatic test_overflow_sticky();
        out_ready = 1'b1;
        issue(3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd2);
        in_valid = 1'b0;
        cyc();
        n_tests++;
        if (out_overflow !== 1'b1 || ovf_sticky !== 1'b1) begin
            n_fail++; $display("FAIL sub_overflow ovf=%b sticky=%b exp 1 1", out_overflow, ovf_sticky);
        end
        issue(3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd3);
        in_valid = 1'b0;
        clr_sticky = 1'b1;
        cyc();
        n_tests++;
        if (ovf_sticky !== 1'b1 || out_overflow !== 1'b1) begin
            n_fail++; $display("FAIL sticky_set_wins sticky=%b ovf=%b exp 1 1", ovf_sticky, out_overflow);
        end
        cyc();
        clr_sticky = 1'b0;
        n_tests++;
        if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky_clear sticky=%b exp 0", ovf_sticky); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        obs_q.delete();
        issue(3'b010, 32'd10, 32'd3, 1'b0, 4'd4);
        issue(3'b010, 32'd0, 32'd4, 1'b1, 4'd5);
        issue(3'b110, 32'd0, 32'd17, 1'b1, 4'd6);
        drain(4);
        n_tests++;
        if (obs_q.size() != 3) begin
            n_fail++; $display("FAIL acc_count got %0d exp 3", obs_q.size());
        end else begin
            n_tests++;
            if ({obs_q[0].res, obs_q[1].res, obs_q[2].res, obs_q[2].zero} !== {32'd13, 32'd17, 32'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL acc_results got %0d %0d %0d zero=%b exp 13 17 0 zero=1",
                         obs_q[0].res, obs_q[1].res, obs_q[2].res, obs_q[2].zero);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_res;
        logic [3:0]  held_tag;
        int          unstable;
        out_ready = 1'b0;
        obs_q.delete();
        in_valid = 1'b1; in_op = 3'b010; in_a = 32'd100; in_b = 32'd1; in_acc = 1'b0; in_tag = 4'd1;
        cyc();
        n_tests++;
        if (last_acc !== 1'b1) begin n_fail++; $display("FAIL bp_first_accept acc=%b exp 1", last_acc); end
        in_a = 32'd200; in_tag = 4'd2;
        cyc();
        n_tests++;
        if (last_acc !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept acc=%b exp 1", last_acc); end
        in_a = 32'd300; in_tag = 4'd3;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        held_res = out_result;
        held_tag = out_tag;
        unstable = 0;
        repeat (3) begin
            cyc();
            if (last_acc || !out_valid || out_result !== held_res || out_tag !== held_tag) unstable++;
        end
        n_tests++;
        if (unstable != 0 || held_tag !== 4'd1 || held_res !== 32'd101) begin
            n_fail++;
            $display("FAIL bp_hold unstable=%0d tag=%0d res=%0d exp 0 1 101", unstable, held_tag, held_res);
        end
        out_ready = 1'b1;
        issue(3'b010, 32'd300, 32'd1, 1'b0, 4'd3);
        drain(4);
        n_tests++;
        if (obs_q.size() != 3) begin
            n_fail++; $display("FAIL bp_count got %0d exp 3", obs_q.size());
        end else begin
            n_tests++;
            if ({obs_q[0].tag, obs_q[1].tag, obs_q[2].tag} !== {4'd1, 4'd2, 4'd3}) begin
                n_fail++;
                $display("FAIL bp_order got %0d %0d %0d exp 1 2 3", obs_q[0].tag, obs_q[1].tag, obs_q[2].tag);
            end
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        obs_q.delete();
        issue(3'b010, 32'd20, 32'd5, 1'b0, 4'd7);
        issue(3'b100, 32'd9, 32'd9, 1'b0, 4'd8);
        issue(3'b010, 32'd0, 32'd1, 1'b1, 4'd9);
        drain(4);
        n_tests++;
        if (obs_q.size() != 3) begin
            n_fail++; $display("FAIL ill_count got %0d exp 3", obs_q.size());
        end else begin
            n_tests++;
            if ({obs_q[0].ill, obs_q[1].ill, obs_q[1].res, obs_q[1].ovf, obs_q[2].res} !==
                {1'b0, 1'b1, 32'd0, 1'b0, 32'd26}) begin
                n_fail++;
                $display("FAIL ill_op ill0=%b ill1=%b res1=%0d ovf1=%b res2=%0d exp 0 1 0 0 26",
                         obs_q[0].ill, obs_q[1].ill, obs_q[1].res, obs_q[1].ovf, obs_q[2].res);
            end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        issue(3'b010, 32'd1, 32'd1, 1'b0, 4'd5);
        issue(3'b010, 32'd2, 32'd2, 1'b0, 4'd6);
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_full out_valid=%b in_ready=%b exp 1 0", out_valid, in_ready);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_result, out_tag, retire_count} !== {1'b0, 1'b0, 32'd0, 4'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL mid_async_clear valid=%b rdy=%b res=%h tag=%h cnt=%0d exp 0 0 0 0 0",
                     out_valid, in_ready, out_result, out_tag, retire_count);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.delete(); obs_q.delete(); m_acc = '0; ret_total = 0;
        out_ready = 1'b1;
        drain(3);
        n_tests++;
        if (obs_q.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after_release retired=%0d valid=%b rdy=%b exp 0 0 1", obs_q.size(), out_valid, in_ready);
        end
        in_valid = 1'b1; in_op = 3'b010; in_a = 32'd1; in_b = 32'd2; in_acc = 1'b1; in_tag = 4'd7;
        cyc();
        n_tests++;
        if (last_acc !== 1'b1) begin n_fail++; $display("FAIL mid_reaccept acc=%b exp 1", last_acc); end
        drain(3);
        n_tests++;
        if (obs_q.size() != 1 || obs_q[0].res !== 32'd2 || obs_q[0].tag !== 4'd7) begin
            n_fail++; $display("FAIL mid_exec count=%0d res/tag mismatch exp 1 result 2 tag 7", obs_q.size());
        end
    endtask

    task automatic test_random();
        int errs;
        exp_q.delete(); obs_q.delete();
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_op    = 3'($urandom_range(0, 7));
                in_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                in_b     = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
                in_acc   = $urandom_range(0, 1) == 1;
                in_tag   = 4'($urandom);
            end
            out_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 15) == 0);
            cyc();
        end
        clr_sticky = 1'b0;
        out_ready = 1'b1;
        drain(5);
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        errs = 0;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                if (errs < 5)
                    $display("FAIL rand_item[%0d] got tag=%h res=%h z=%b o=%b i=%b exp tag=%h res=%h z=%b o=%b i=%b", i,
                             obs_q[i].tag, obs_q[i].res, obs_q[i].zero, obs_q[i].ovf, obs_q[i].ill,
                             exp_q[i].tag, exp_q[i].res, exp_q[i].zero, exp_q[i].ovf, exp_q[i].ill);
                errs++;
            end
        end
        n_tests++;
        if (retire_count !== 16'(ret_total)) begin
            n_fail++; $display("FAIL rand_retire_count got %0d exp %0d", retire_count, 16'(ret_total));
        end
    endtask

    task automatic test_wrap();
        int guard;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'b001; in_a = 32'd1; in_b = 32'd2; in_acc = 1'b0; in_tag = 4'd0;
        guard = 0;
        while (ret_total < 65535 && guard < 70000) begin
            cyc();
            guard++;
            if (obs_q.size() > 1000) begin obs_q.delete(); exp_q.delete(); end
        end
        n_tests++;
        if (ret_total != 65535 || retire_count !== 16'hFFFF) begin
            n_fail++; $display("FAIL wrap_top got %0d retired=%0d exp 65535", retire_count, ret_total);
        end
        cyc();
        in_valid = 1'b0;
        n_tests++;
        if (ret_total != 65536 || retire_count !== 16'd0) begin
            n_fail++; $display("FAIL wrap_zero got %0d retired=%0d exp 0", retire_count, ret_total);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_overflow_sticky();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
